// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard/stall controller.
// Holds the FSM state enum, the default register-index width and the control bundle.
package hazard_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int CNT_W      = 2;

    typedef enum logic {
        HZ_RUN,
        HZ_STALL
    } hz_state_e;

    typedef struct packed {
        logic pc_write;
        logic pc_src_branch;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_write;
        logic id_ex_flush;
        logic ex_mem_write;
        logic mem_wb_flush;
    } pipe_ctrl_t;

    localparam pipe_ctrl_t CTRL_RUN    = pipe_ctrl_t'(8'b1010_1010);
    localparam pipe_ctrl_t CTRL_STALL  = pipe_ctrl_t'(8'b0000_1110);
    localparam pipe_ctrl_t CTRL_BRANCH = pipe_ctrl_t'(8'b1111_1110);
    localparam pipe_ctrl_t CTRL_FREEZE = pipe_ctrl_t'(8'b0000_0001);
    localparam pipe_ctrl_t CTRL_RESET  = pipe_ctrl_t'(8'b0001_0101);

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard detector for one ID-stage instruction.
// Ports: rs_i/rt_i/uses_rs_i/uses_rt_i (ID sources), rt_ex_i/mem_read_ex_i (EX load), load_use_o.
module load_use_detect #(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] rs_i,
    input  logic [REG_ADDR_W-1:0] rt_i,
    input  logic                  uses_rs_i,
    input  logic                  uses_rt_i,
    input  logic [REG_ADDR_W-1:0] rt_ex_i,
    input  logic                  mem_read_ex_i,
    output logic                  load_use_o
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit = uses_rs_i && (rs_i == rt_ex_i);
    assign rt_hit = uses_rt_i && (rt_i == rt_ex_i);

    // Register 0 is hard-wired zero, so a load into it never produces data.
    assign load_use_o = mem_read_ex_i && (rt_ex_i != '0) && (rs_hit || rt_hit);

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for PC, IF/ID, ID/EX, EX/MEM and MEM/WB (load-use, mem wait, branch).
// Ports: clk, rst_n, ID/EX hazard inputs, branch_taken_ex, mem_busy; write/flush controls,
// stall_active. Macro HAZARD_PERF_CNT_EN adds stall_cycles and flush_events counters.
module hazard_stall_unit #(
    parameter int LOAD_USE_BUBBLES = 1,
    parameter int REG_ADDR_W       = hazard_pkg::REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] rs_if_id,
    input  logic [REG_ADDR_W-1:0] rt_if_id,
    input  logic                  uses_rs_id,
    input  logic                  uses_rt_id,
    input  logic [REG_ADDR_W-1:0] rt_id_ex,
    input  logic                  mem_read_id_ex,
    input  logic                  branch_taken_ex,
    input  logic                  mem_busy,
    output logic                  pc_write,
    output logic                  pc_src_branch,
    output logic                  if_id_write,
    output logic                  if_id_flush,
    output logic                  id_ex_write,
    output logic                  id_ex_flush,
    output logic                  ex_mem_write,
    output logic                  mem_wb_flush,
    output logic                  stall_active
`ifdef HAZARD_PERF_CNT_EN
    ,
    output logic [31:0]           stall_cycles,
    output logic [31:0]           flush_events
`endif
);

    import hazard_pkg::*;

    if (LOAD_USE_BUBBLES < 1 || LOAD_USE_BUBBLES > 3) begin : g_bad_param
        $error("LOAD_USE_BUBBLES must be in 1..3");
    end

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LOAD_USE_BUBBLES - 1);

    hz_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    pipe_ctrl_t       ctrl;
    logic             load_use;

    load_use_detect #(
        .REG_ADDR_W(REG_ADDR_W)
    ) u_lud (
        .rs_i          (rs_if_id),
        .rt_i          (rt_if_id),
        .uses_rs_i     (uses_rs_id),
        .uses_rt_i     (uses_rt_id),
        .rt_ex_i       (rt_id_ex),
        .mem_read_ex_i (mem_read_id_ex),
        .load_use_o    (load_use)
    );

    always_comb begin
        ctrl    = CTRL_RUN;
        state_d = state_q;
        cnt_d   = cnt_q;
        if (mem_busy) begin
            // Whole pipe holds; EX is kept so branch/load-use re-evaluate later.
            ctrl = CTRL_FREEZE;
        end else if (branch_taken_ex) begin
            // Anything still stalled in ID is wrong-path, so drop the stall.
            ctrl    = CTRL_BRANCH;
            state_d = HZ_RUN;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                HZ_RUN: begin
                    if (load_use) begin
                        ctrl = CTRL_STALL;
                        if (LOAD_USE_BUBBLES > 1) begin
                            state_d = HZ_STALL;
                            cnt_d   = CNT_INIT;
                        end
                    end
                end
                HZ_STALL: begin
                    ctrl  = CTRL_STALL;
                    cnt_d = cnt_q - 2'd1;
                    if (cnt_q == 2'd1) begin
                        state_d = HZ_RUN;
                    end
                end
                default: begin
                    state_d = HZ_RUN;
                    cnt_d   = '0;
                end
            endcase
        end
        if (!rst_n) begin
            ctrl = CTRL_RESET;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= HZ_RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc_write      = ctrl.pc_write;
    assign pc_src_branch = ctrl.pc_src_branch;
    assign if_id_write   = ctrl.if_id_write;
    assign if_id_flush   = ctrl.if_id_flush;
    assign id_ex_write   = ctrl.id_ex_write;
    assign id_ex_flush   = ctrl.id_ex_flush;
    assign ex_mem_write  = ctrl.ex_mem_write;
    assign mem_wb_flush  = ctrl.mem_wb_flush;
    assign stall_active  = (state_q == HZ_STALL);

`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cycles_q;
    logic [31:0] flush_events_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles_q <= '0;
            flush_events_q <= '0;
        end else begin
            if (!ctrl.pc_write && stall_cycles_q != 32'hFFFF_FFFF) begin
                stall_cycles_q <= stall_cycles_q + 32'd1;
            end
            if (ctrl.pc_src_branch && flush_events_q != 32'hFFFF_FFFF) begin
                flush_events_q <= flush_events_q + 32'd1;
            end
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_events = flush_events_q;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit with LOAD_USE_BUBBLES=1 and =3 side by side.
// Both instances share stimulus; each vector carries hand-computed outputs for both.
module tb_hazard_stall_unit;

    // {pc_write,pc_src_branch,if_id_write,if_id_flush,
    //  id_ex_write,id_ex_flush,ex_mem_write,mem_wb_flush,stall_active}
    localparam logic [8:0] RUNV = 9'b1010_1010_0;
    localparam logic [8:0] LU0  = 9'b0000_1110_0;
    localparam logic [8:0] LU1  = 9'b0000_1110_1;
    localparam logic [8:0] BR0  = 9'b1111_1110_0;
    localparam logic [8:0] BR1  = 9'b1111_1110_1;
    localparam logic [8:0] FZ0  = 9'b0000_0001_0;
    localparam logic [8:0] FZ1  = 9'b0000_0001_1;
    localparam logic [8:0] RSTV = 9'b0001_0101_0;

    typedef struct {
        string      name;
        logic [8:0] e3;
        logic [8:0] e1;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] rs_if_id = '0;
    logic [4:0] rt_if_id = '0;
    logic       uses_rs_id = 1'b0;
    logic       uses_rt_id = 1'b0;
    logic [4:0] rt_id_ex = '0;
    logic       mem_read_id_ex = 1'b0;
    logic       branch_taken_ex = 1'b0;
    logic       mem_busy = 1'b0;

    logic [8:0] got3, got1;
    logic p3, s3, iw3, if3, dw3, df3, ew3, wf3, sa3;
    logic p1, s1, iw1, if1, dw1, df1, ew1, wf1, sa1;

    always #5 clk = ~clk;

    hazard_stall_unit #(.LOAD_USE_BUBBLES(3), .REG_ADDR_W(5)) u3 (
        .clk(clk), .rst_n(rst_n),
        .rs_if_id(rs_if_id), .rt_if_id(rt_if_id),
        .uses_rs_id(uses_rs_id), .uses_rt_id(uses_rt_id),
        .rt_id_ex(rt_id_ex), .mem_read_id_ex(mem_read_id_ex),
        .branch_taken_ex(branch_taken_ex), .mem_busy(mem_busy),
        .pc_write(p3), .pc_src_branch(s3),
        .if_id_write(iw3), .if_id_flush(if3),
        .id_ex_write(dw3), .id_ex_flush(df3),
        .ex_mem_write(ew3), .mem_wb_flush(wf3),
        .stall_active(sa3)
    );

    hazard_stall_unit #(.LOAD_USE_BUBBLES(1), .REG_ADDR_W(5)) u1 (
        .clk(clk), .rst_n(rst_n),
        .rs_if_id(rs_if_id), .rt_if_id(rt_if_id),
        .uses_rs_id(uses_rs_id), .uses_rt_id(uses_rt_id),
        .rt_id_ex(rt_id_ex), .mem_read_id_ex(mem_read_id_ex),
        .branch_taken_ex(branch_taken_ex), .mem_busy(mem_busy),
        .pc_write(p1), .pc_src_branch(s1),
        .if_id_write(iw1), .if_id_flush(if1),
        .id_ex_write(dw1), .id_ex_flush(df1),
        .ex_mem_write(ew1), .mem_wb_flush(wf1),
        .stall_active(sa1)
    );

    assign got3 = {p3, s3, iw3, if3, dw3, df3, ew3, wf3, sa3};
    assign got1 = {p1, s1, iw1, if1, dw1, df1, ew1, wf1, sa1};

    // Monitor: outputs are valid every cycle; compare mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                checks++;
                if (got3 !== e.e3) begin
                    errors++;
                    $display("FAIL %s [B=3] got %b exp %b", e.name, got3, e.e3);
                end
                checks++;
                if (got1 !== e.e1) begin
                    errors++;
                    $display("FAIL %s [B=1] got %b exp %b", e.name, got1, e.e1);
                end
            end
        end
    end

    task automatic step(input string nm,
                        input logic [4:0] rs, input logic [4:0] rt,
                        input logic urs, input logic urt,
                        input logic [4:0] rtex, input logic mr,
                        input logic br, input logic busy,
                        input logic rst, input logic pulse,
                        input logic [8:0] e3, input logic [8:0] e1);
        exp_t e;
        @(posedge clk);
        #1;
        rs_if_id        = rs;
        rt_if_id        = rt;
        uses_rs_id      = urs;
        uses_rt_id      = urt;
        rt_id_ex        = rtex;
        mem_read_id_ex  = mr;
        branch_taken_ex = br;
        mem_busy        = busy;
        rst_n           = rst;
        e.name = nm;
        e.e3   = e3;
        e.e1   = e1;
        sbq.push_back(e);
        if (pulse) begin
            rst_n = 1'b0;
            #2;
            rst_n = 1'b1;
        end
    endtask

    initial begin
        step("reset_hold", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, RSTV, RSTV);
        step("idle",       0, 0, 0, 0, 0, 0, 0, 0, 1, 0, RUNV, RUNV);
        // load-use through Rs
        step("lu_c1",      8, 0, 1, 0, 8, 1, 0, 0, 1, 0, LU0,  LU0);
        step("lu_c2",      0, 0, 0, 0, 0, 0, 0, 0, 1, 0, LU1,  RUNV);
        step("lu_c3",      0, 0, 0, 0, 0, 0, 0, 0, 1, 0, LU1,  RUNV);
        step("lu_done",    0, 0, 0, 0, 0, 0, 0, 0, 1, 0, RUNV, RUNV);
        // register 0 and unused Rt never hazard
        step("zero_reg",   0, 0, 1, 0, 0, 1, 0, 0, 1, 0, RUNV, RUNV);
        step("rt_unused",  3, 5, 1, 0, 5, 1, 0, 0, 1, 0, RUNV, RUNV);
        step("rt_hit",     3, 5, 1, 1, 5, 1, 0, 0, 1, 0, LU0,  LU0);
        // branch aborts stall
        step("br_in_stall",0, 0, 0, 0, 0, 0, 1, 0, 1, 0, BR1,  BR0);
        step("br_after",   0, 0, 0, 0, 0, 0, 0, 0, 1, 0, RUNV, RUNV);
        // freeze mid-stall, branch and hazard ignored while busy
        step("fz_lu",      8, 0, 1, 0, 8, 1, 0, 0, 1, 0, LU0,  LU0);
        step("fz_1",       0, 0, 0, 0, 0, 0, 0, 1, 1, 0, FZ1,  FZ0);
        step("fz_2_br",    0, 0, 0, 0, 0, 0, 1, 1, 1, 0, FZ1,  FZ0);
        step("fz_3_lu",    8, 0, 1, 0, 8, 1, 0, 1, 1, 0, FZ1,  FZ0);
        step("fz_4",       0, 0, 0, 0, 0, 0, 0, 1, 1, 0, FZ1,  FZ0);
        step("fz_post1",   0, 0, 0, 0, 0, 0, 0, 0, 1, 0, LU1,  RUNV);
        step("fz_post2",   0, 0, 0, 0, 0, 0, 0, 0, 1, 0, LU1,  RUNV);
        step("fz_done",    0, 0, 0, 0, 0, 0, 0, 0, 1, 0, RUNV, RUNV);
        // reset pulse between edges while in STALL
        step("rst_lu",     8, 0, 1, 0, 8, 1, 0, 0, 1, 0, LU0,  LU0);
        step("rst_pulse",  0, 0, 0, 0, 0, 0, 0, 0, 1, 1, RUNV, RUNV);
        step("rst_lu2",    8, 0, 1, 0, 8, 1, 0, 0, 1, 0, LU0,  LU0);
        step("rst_held",   8, 0, 1, 0, 8, 1, 1, 1, 0, 0, RSTV, RSTV);
        step("rst_rel",    0, 0, 0, 0, 0, 0, 0, 0, 1, 0, RUNV, RUNV);

        for (int i = 0; i < 20 && sbq.size() > 0; i++) begin
            @(negedge clk);
            #1;
        end
        if (sbq.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, required 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
